// File: rtl/ysyx_23060236_icache.sv
// Direct-mapped instruction cache: combinational lookup, strictly in-order
// 8-word line fill from the fetch burst, and global invalidation on fence_i.
module ysyx_23060236_icache #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] icache_araddr,
  output logic [31:0] icache_rdata,
  output logic        icache_hit,
  input  logic [31:0] icache_awaddr,
  input  logic [31:0] icache_wdata,
  input  logic        icache_wvalid,
  input  logic        fence_i,
  output logic        fill_busy,
  output logic        fill_err
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t             r_state;
  logic [2:0]         r_cnt;
  logic [IDX_W-1:0]   r_fidx;
  logic [TAG_W-1:0]   r_ftag;
  logic               r_err;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS][LINE_WORDS];

  state_t             w_state_nxt;
  logic [2:0]         w_cnt_nxt;
  logic [IDX_W-1:0]   w_fidx_nxt;
  logic [TAG_W-1:0]   w_ftag_nxt;
  logic               w_err_nxt;
  logic               w_we;
  logic               w_tag_we;
  logic [IDX_W-1:0]   w_widx;
  logic [2:0]         w_wword;
  logic               w_vclr;
  logic               w_vset;

  logic [IDX_W-1:0]   w_ar_idx;
  logic [TAG_W-1:0]   w_ar_tag;
  logic [2:0]         w_ar_word;
  logic [IDX_W-1:0]   w_aw_idx;
  logic [TAG_W-1:0]   w_aw_tag;
  logic [2:0]         w_aw_word;
  logic               w_unused;

  assign w_ar_idx  = icache_araddr[4+IDX_W:5];
  assign w_ar_tag  = icache_araddr[31:5+IDX_W];
  assign w_ar_word = icache_araddr[4:2];
  assign w_aw_idx  = icache_awaddr[4+IDX_W:5];
  assign w_aw_tag  = icache_awaddr[31:5+IDX_W];
  assign w_aw_word = icache_awaddr[4:2];
  assign w_unused  = ^{icache_araddr[1:0], icache_awaddr[1:0]};

  assign icache_hit   = r_valid[w_ar_idx] && (r_tag[w_ar_idx] == w_ar_tag);
  assign icache_rdata = r_data[w_ar_idx][w_ar_word];
  assign fill_busy    = (r_state == S_FILL);
  assign fill_err     = r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_fidx  <= '0;
      r_ftag  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fidx  <= w_fidx_nxt;
      r_ftag  <= w_ftag_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // fence_i outranks any fill word in the same cycle: that word is dropped silently.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fidx_nxt  = r_fidx;
    w_ftag_nxt  = r_ftag;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    w_tag_we    = 1'b0;
    w_widx      = r_fidx;
    w_wword     = r_cnt;
    w_vclr      = 1'b0;
    w_vset      = 1'b0;
    if (fence_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 3'd0;
    end else if (icache_wvalid) begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_word == 3'd0) begin
            w_we        = 1'b1;
            w_tag_we    = 1'b1;
            w_widx      = w_aw_idx;
            w_wword     = 3'd0;
            w_vclr      = 1'b1;
            w_fidx_nxt  = w_aw_idx;
            w_ftag_nxt  = w_aw_tag;
            w_cnt_nxt   = 3'd1;
            w_state_nxt = S_FILL;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        S_FILL: begin
          if (w_aw_idx == r_fidx && w_aw_tag == r_ftag && w_aw_word == r_cnt) begin
            w_we      = 1'b1;
            w_cnt_nxt = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_vset      = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (fence_i) begin
      r_valid <= '0;
    end else if (w_vclr) begin
      r_valid[w_widx] <= 1'b0;
    end else if (w_vset) begin
      r_valid[r_fidx] <= 1'b1;
    end
  end

  // Tag and data arrays are never reset; valid[] alone decides visibility.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_data[w_widx][w_wword] <= icache_wdata;
    end
    if (w_tag_we) begin
      r_tag[w_widx] <= w_aw_tag;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_icache.sv
// Directed testbench for ysyx_23060236_icache: fills, conflicts, protocol
// errors, fence_i and asynchronous reset mid-fill.
module tb_ysyx_23060236_icache;

  logic        clock;
  logic        reset;
  logic [31:0] icache_araddr;
  logic [31:0] icache_rdata;
  logic        icache_hit;
  logic [31:0] icache_awaddr;
  logic [31:0] icache_wdata;
  logic        icache_wvalid;
  logic        fence_i;
  logic        fill_busy;
  logic        fill_err;

  int passCount;
  int checkCount;

  ysyx_23060236_icache dut (
    .clock         (clock),
    .reset         (reset),
    .icache_araddr (icache_araddr),
    .icache_rdata  (icache_rdata),
    .icache_hit    (icache_hit),
    .icache_awaddr (icache_awaddr),
    .icache_wdata  (icache_wdata),
    .icache_wvalid (icache_wvalid),
    .fence_i       (fence_i),
    .fill_busy     (fill_busy),
    .fill_err      (fill_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1 time unit after each rising edge, leaving them stable for the next edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doWord(input logic [31:0] addr, input logic [31:0] data);
    icache_awaddr = addr;
    icache_wdata  = data;
    icache_wvalid = 1'b1;
    step();
    icache_wvalid = 1'b0;
  endtask

  task automatic fillLine(input logic [31:0] base, input logic [31:0] dbase);
    for (int n = 0; n < 8; n++) doWord(base + 32'(4 * n), dbase + 32'(n));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    icache_araddr = 32'h3000_0000;
    icache_awaddr = 32'h0;
    icache_wdata  = 32'h0;
    icache_wvalid = 1'b0;
    fence_i       = 1'b0;
    #3;
    checkCount++;
    if (icache_hit !== 1'b0) $display("[TB] FAIL reset_hit: got %b expected 0", icache_hit);
    else passCount++;
    checkCount++;
    if (fill_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", fill_busy);
    else passCount++;
    checkCount++;
    if (fill_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", fill_err);
    else passCount++;
    #9 reset = 1'b1;
    step();
  endtask

  task automatic test_fill();
    icache_araddr = 32'h3000_0000;
    for (int n = 0; n < 8; n++) begin
      icache_awaddr = 32'h3000_0000 + 32'(4 * n);
      icache_wdata  = 32'hA0 + 32'(n);
      icache_wvalid = 1'b1;
      #1;
      checkCount++;
      if (icache_hit !== 1'b0) $display("[TB] FAIL fill_hit_w%0d: got %b expected 0", n, icache_hit);
      else passCount++;
      step();
      checkCount++;
      if (fill_busy !== (n < 7)) $display("[TB] FAIL fill_busy_w%0d: got %b expected %b", n, fill_busy, (n < 7));
      else passCount++;
    end
    icache_wvalid = 1'b0;
    icache_araddr = 32'h3000_0008;
    #1;
    checkCount++;
    if (icache_hit !== 1'b1) $display("[TB] FAIL fill_done_hit: got %b expected 1", icache_hit);
    else passCount++;
    checkCount++;
    if (icache_rdata !== 32'hA2) $display("[TB] FAIL fill_done_rdata: got %h expected %h", icache_rdata, 32'hA2);
    else passCount++;
  endtask

  task automatic test_conflict();
    icache_araddr = 32'h3000_0000;
    for (int n = 0; n < 8; n++) begin
      doWord(32'h3000_0200 + 32'(4 * n), 32'hB0 + 32'(n));
      checkCount++;
      if (icache_hit !== 1'b0) $display("[TB] FAIL conflict_old_hit_w%0d: got %b expected 0", n, icache_hit);
      else passCount++;
    end
    icache_araddr = 32'h3000_0204;
    #1;
    checkCount++;
    if (icache_hit !== 1'b1) $display("[TB] FAIL conflict_new_hit: got %b expected 1", icache_hit);
    else passCount++;
    checkCount++;
    if (icache_rdata !== 32'hB1) $display("[TB] FAIL conflict_new_rdata: got %h expected %h", icache_rdata, 32'hB1);
    else passCount++;
  endtask

  task automatic test_proto_err();
    doWord(32'h3000_0000, 32'h11);
    doWord(32'h3000_0004, 32'h12);
    doWord(32'h3000_000C, 32'h13);
    checkCount++;
    if (fill_err !== 1'b1) $display("[TB] FAIL skip_err_pulse: got %b expected 1", fill_err);
    else passCount++;
    checkCount++;
    if (fill_busy !== 1'b0) $display("[TB] FAIL skip_busy: got %b expected 0", fill_busy);
    else passCount++;
    icache_araddr = 32'h3000_0000;
    #1;
    checkCount++;
    if (icache_hit !== 1'b0) $display("[TB] FAIL skip_line_hit: got %b expected 0", icache_hit);
    else passCount++;
    icache_araddr = 32'h3000_0204;
    #1;
    checkCount++;
    if (icache_hit !== 1'b0) $display("[TB] FAIL skip_evicted_hit: got %b expected 0", icache_hit);
    else passCount++;
    step();
    checkCount++;
    if (fill_err !== 1'b0) $display("[TB] FAIL skip_err_one_cycle: got %b expected 0", fill_err);
    else passCount++;
    doWord(32'h3000_0004, 32'h99);
    checkCount++;
    if (fill_err !== 1'b1) $display("[TB] FAIL idle_err_pulse: got %b expected 1", fill_err);
    else passCount++;
    checkCount++;
    if (fill_busy !== 1'b0) $display("[TB] FAIL idle_err_busy: got %b expected 0", fill_busy);
    else passCount++;
    step();
    checkCount++;
    if (fill_err !== 1'b0) $display("[TB] FAIL idle_err_one_cycle: got %b expected 0", fill_err);
    else passCount++;
  endtask

  task automatic test_fence();
    fillLine(32'h3000_0000, 32'hC0);
    fillLine(32'h3000_0020, 32'hD0);
    icache_araddr = 32'h3000_0000;
    #1;
    checkCount++;
    if (icache_hit !== 1'b1 || icache_rdata !== 32'hC0) $display("[TB] FAIL b2b_line0: got hit=%b data=%h expected hit=1 data=%h", icache_hit, icache_rdata, 32'hC0);
    else passCount++;
    icache_araddr = 32'h3000_003C;
    #1;
    checkCount++;
    if (icache_hit !== 1'b1 || icache_rdata !== 32'hD7) $display("[TB] FAIL b2b_line1: got hit=%b data=%h expected hit=1 data=%h", icache_hit, icache_rdata, 32'hD7);
    else passCount++;
    fence_i = 1'b1;
    step();
    fence_i = 1'b0;
    #1;
    checkCount++;
    if (icache_hit !== 1'b0) $display("[TB] FAIL fence_line1_hit: got %b expected 0", icache_hit);
    else passCount++;
    icache_araddr = 32'h3000_0000;
    #1;
    checkCount++;
    if (icache_hit !== 1'b0) $display("[TB] FAIL fence_line0_hit: got %b expected 0", icache_hit);
    else passCount++;
    for (int n = 0; n < 4; n++) doWord(32'h3000_0040 + 32'(4 * n), 32'hE0 + 32'(n));
    icache_awaddr = 32'h3000_0050;
    icache_wdata  = 32'hE4;
    icache_wvalid = 1'b1;
    fence_i       = 1'b1;
    step();
    icache_wvalid = 1'b0;
    fence_i       = 1'b0;
    checkCount++;
    if (fill_busy !== 1'b0) $display("[TB] FAIL fence_fill_busy: got %b expected 0", fill_busy);
    else passCount++;
    checkCount++;
    if (fill_err !== 1'b0) $display("[TB] FAIL fence_fill_err: got %b expected 0", fill_err);
    else passCount++;
    step();
    icache_araddr = 32'h3000_0040;
    #1;
    checkCount++;
    if (icache_hit !== 1'b0) $display("[TB] FAIL fence_fill_line_hit: got %b expected 0", icache_hit);
    else passCount++;
  endtask

  task automatic test_reset_midfill();
    fillLine(32'h3000_0080, 32'h50);
    icache_araddr = 32'h3000_0084;
    #1;
    checkCount++;
    if (icache_hit !== 1'b1 || icache_rdata !== 32'h51) $display("[TB] FAIL pre_reset_line: got hit=%b data=%h expected hit=1 data=%h", icache_hit, icache_rdata, 32'h51);
    else passCount++;
    for (int n = 0; n < 5; n++) doWord(32'h3000_0060 + 32'(4 * n), 32'h60 + 32'(n));
    #1 reset = 1'b0;
    #1;
    checkCount++;
    if (fill_busy !== 1'b0) $display("[TB] FAIL async_reset_busy: got %b expected 0", fill_busy);
    else passCount++;
    checkCount++;
    if (icache_hit !== 1'b0) $display("[TB] FAIL async_reset_hit: got %b expected 0", icache_hit);
    else passCount++;
    @(negedge clock);
    reset = 1'b1;
    step();
    fillLine(32'h3000_0060, 32'hF0);
    icache_araddr = 32'h3000_007C;
    #1;
    checkCount++;
    if (icache_hit !== 1'b1 || icache_rdata !== 32'hF7) $display("[TB] FAIL refill_after_reset: got hit=%b data=%h expected hit=1 data=%h", icache_hit, icache_rdata, 32'hF7);
    else passCount++;
    icache_araddr = 32'h3000_0080;
    #1;
    checkCount++;
    if (icache_hit !== 1'b0) $display("[TB] FAIL reset_cleared_other: got %b expected 0", icache_hit);
    else passCount++;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    test_reset();
    test_fill();
    test_conflict();
    test_proto_err();
    test_fence();
    test_reset_midfill();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
